// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_pkg
// Description : Shared encodings for the MIPS-subset main decoder: opcodes,
//               R-type funct codes, ALU operation selects, the ALUOp handoff
//               between the main decode and the ALU decoder, and the bundle
//               of 1-bit datapath controls.
// Revision    : 1.0 - initial release
// ============================================================================
package control_pkg;

  // Instruction opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  // R-type funct codes, instruction bits [5:0]
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU operation selects
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALUOp from the main decode to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // 1-bit datapath controls, kept together so reset and defaults clear all
  typedef struct packed {
    logic mtorfsel;
    logic dmwe;
    logic branch;
    logic aluinsel;
    logic rfdsel;
    logic rfwe;
  } ctrl_t;

  // True only for the five supported R-type functions; unknown or unlisted
  // values land in the default arm so they never enable a write.
  function automatic logic funct_valid(input logic [5:0] fn);
    logic v;
    v = 1'b0;
    case (fn)
      F_ADD, F_SUB, F_AND, F_OR, F_SLT: v = 1'b1;
      default:                          v = 1'b0;
    endcase
    return v;
  endfunction

endpackage : control_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational mapping of ALUOp and the R-type funct field to
//               the 4-bit ALU operation select. Anything not recognised
//               resolves to ADD.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
  import control_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] alusel
);

  // Select the ALU operation; funct only matters for the by-funct ALUOp
  always_comb begin
    alusel = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alusel = ALU_ADD;
      ALUOP_SUB: alusel = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alusel = ALU_ADD;
          F_SUB:   alusel = ALU_SUB;
          F_AND:   alusel = ALU_AND;
          F_OR:    alusel = ALU_OR;
          F_SLT:   alusel = ALU_SLT;
          default: alusel = ALU_ADD;
        endcase
      end
      default: alusel = ALU_ADD;
    endcase
  end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Main decoder for the single-cycle MIPS-subset datapath.
//               Decodes Opcode (and funct for R-type) into steering and
//               write-enable controls plus ALUsel, registered with one cycle
//               of latency and a synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] funct,
  output logic       MtoRFSel,
  output logic       DMWE,
  output logic       Branch,
  output logic       ALUInSel,
  output logic       RFDSel,
  output logic       RFWE,
  output logic [3:0] ALUsel
);

  ctrl_t      w_ctrl;
  logic [1:0] w_aluop;
  logic [3:0] w_alusel;
  ctrl_t      r_ctrl;
  logic [3:0] r_alusel;

  // Main opcode decode; unlisted or unknown opcodes fall through as a NOP
  always_comb begin
    w_ctrl  = '0;
    w_aluop = ALUOP_ADD;
    case (Opcode)
      OP_RTYPE: begin
        // An unsupported funct must not write the register file
        if (funct_valid(funct)) begin
          w_ctrl.rfwe   = 1'b1;
          w_ctrl.rfdsel = 1'b1;
          w_aluop       = ALUOP_FUNCT;
        end
      end
      OP_LW: begin
        w_ctrl.rfwe     = 1'b1;
        w_ctrl.aluinsel = 1'b1;
        w_ctrl.mtorfsel = 1'b1;
        w_aluop         = ALUOP_ADD;
      end
      OP_SW: begin
        w_ctrl.dmwe     = 1'b1;
        w_ctrl.aluinsel = 1'b1;
        w_aluop         = ALUOP_ADD;
      end
      OP_BEQ: begin
        w_ctrl.branch = 1'b1;
        w_aluop       = ALUOP_SUB;
      end
      default: begin
        w_ctrl  = '0;
        w_aluop = ALUOP_ADD;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop  (w_aluop),
    .funct  (funct),
    .alusel (w_alusel)
  );

  // Output register; reset wins over the decode in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl   <= '0;
      r_alusel <= 4'b0000;
    end else begin
      r_ctrl   <= w_ctrl;
      r_alusel <= w_alusel;
    end
  end

  assign MtoRFSel = r_ctrl.mtorfsel;
  assign DMWE     = r_ctrl.dmwe;
  assign Branch   = r_ctrl.branch;
  assign ALUInSel = r_ctrl.aluinsel;
  assign RFDSel   = r_ctrl.rfdsel;
  assign RFWE     = r_ctrl.rfwe;
  assign ALUsel   = r_alusel;

endmodule : control_unit
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit: directed walk through
//               reset, R-type, memory, branch and illegal encodings, then
//               randomized opcode/funct/reset traffic against a table-driven
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] Opcode;
  logic [5:0] funct;
  logic       MtoRFSel;
  logic       DMWE;
  logic       Branch;
  logic       ALUInSel;
  logic       RFDSel;
  logic       RFWE;
  logic [3:0] ALUsel;

  int errors = 0;
  int checks = 0;

  control_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Opcode   (Opcode),
    .funct    (funct),
    .MtoRFSel (MtoRFSel),
    .DMWE     (DMWE),
    .Branch   (Branch),
    .ALUInSel (ALUInSel),
    .RFDSel   (RFDSel),
    .RFWE     (RFWE),
    .ALUsel   (ALUsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {MtoRFSel, DMWE, Branch, ALUInSel, RFDSel, RFWE, ALUsel}
  function automatic logic [9:0] observed();
    return {MtoRFSel, DMWE, Branch, ALUInSel, RFDSel, RFWE, ALUsel};
  endfunction

  // Reference: the decode table written out as per-instruction rows
  function automatic logic [9:0] model(input logic rn, input logic [5:0] op,
                                       input logic [5:0] fn);
    logic m, d, b, ai, rd, we;
    logic [3:0] alu;
    m = 0; d = 0; b = 0; ai = 0; rd = 0; we = 0; alu = 4'd2;
    if (!rn) return 10'd0;
    if (op == 6'd0) begin
      if      (fn == 6'd32) begin we = 1; rd = 1; alu = 4'd2; end
      else if (fn == 6'd34) begin we = 1; rd = 1; alu = 4'd6; end
      else if (fn == 6'd36) begin we = 1; rd = 1; alu = 4'd0; end
      else if (fn == 6'd37) begin we = 1; rd = 1; alu = 4'd1; end
      else if (fn == 6'd42) begin we = 1; rd = 1; alu = 4'd7; end
    end else if (op == 6'd35) begin
      we = 1; ai = 1; m = 1;
    end else if (op == 6'd43) begin
      d = 1; ai = 1;
    end else if (op == 6'd4) begin
      b = 1; alu = 4'd6;
    end
    return {m, d, b, ai, rd, we, alu};
  endfunction

  task automatic check(input string tag, input logic [9:0] got,
                       input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs away from the edge, let one edge pass, compare the result
  task automatic step(input string tag, input logic rn, input logic [5:0] op,
                      input logic [5:0] fn);
    @(negedge clk);
    rst_n  = rn;
    Opcode = op;
    funct  = fn;
    @(posedge clk);
    #1;
    check(tag, observed(), model(rn, op, fn));
  endtask

  logic [5:0] legal_fn [5];

  initial begin
    legal_fn = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    rst_n  = 1'b0;
    Opcode = 6'd0;
    funct  = 6'b100000;

    // Reset held for two edges, then released onto an add
    step("reset0", 1'b0, 6'd0, 6'b100000);
    step("reset1", 1'b0, 6'd0, 6'b100000);
    check("reset_const", observed(), 10'd0);
    step("release_add", 1'b1, 6'd0, 6'b100000);
    check("release_add_abs", observed(), 10'b00_0011_0010);

    // R-type sweep
    step("r_add", 1'b1, 6'd0, 6'b100000);
    step("r_sub", 1'b1, 6'd0, 6'b100010);
    check("r_sub_abs", observed(), 10'b00_0011_0110);
    step("r_and", 1'b1, 6'd0, 6'b100100);
    step("r_or",  1'b1, 6'd0, 6'b100101);
    step("r_slt", 1'b1, 6'd0, 6'b101010);
    check("r_slt_abs", observed(), 10'b00_0011_0111);

    // Memory ops
    step("lw", 1'b1, 6'd35, 6'b000000);
    check("lw_abs", observed(), 10'b10_0101_0010);
    step("sw", 1'b1, 6'd43, 6'b101010);
    check("sw_abs", observed(), 10'b01_0100_0010);

    // Branch with a funct that must be ignored
    step("beq", 1'b1, 6'd4, 6'b100100);
    check("beq_abs", observed(), 10'b00_1000_0110);

    // Illegal encodings
    step("r_bad_funct", 1'b1, 6'd0, 6'b000000);
    check("r_bad_abs", observed(), 10'b00_0000_0010);
    step("op63", 1'b1, 6'd63, 6'b100000);

    // Mid-stream reset while a store is presented
    step("sw_pre", 1'b1, 6'd43, 6'd0);
    step("sw_rst", 1'b0, 6'd43, 6'd0);
    check("sw_rst_dmwe", {9'd0, DMWE}, 10'd0);
    step("sw_rst_hold", 1'b0, 6'd43, 6'd0);
    check("sw_rst_hold_dmwe", {9'd0, DMWE}, 10'd0);
    step("after_rst_nop", 1'b1, 6'd0, 6'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op, fn;
      logic rn;
      int sel;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0, 1, 2: op = 6'd0;
        3:       op = 6'd35;
        4:       op = 6'd43;
        5:       op = 6'd4;
        default: op = 6'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) fn = legal_fn[$urandom_range(0, 4)];
      else                           fn = 6'($urandom);
      rn = ($urandom_range(0, 15) != 0);
      step("random", rn, op, fn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_control_unit
`default_nettype wire
